// File: rtl/led_pkg.sv
// Shared FSM encoding and width helper for the LED breathing controller.
package led_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HI   = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LO   = 3'd4
   } state_t;

   function automatic int unsigned max_level(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

endpackage

// File: rtl/led_breather_pwm_gen.sv
// Glitch-free PWM: duty is latched only at the period wrap, period is MAX clocks.
module pwm_gen
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic [PWM_BITS-1:0] duty_i,
   output logic                pwm_o
);

   localparam logic [PWM_BITS-1:0] LAST = PWM_BITS'(max_level(PWM_BITS) - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_q;

   // clr_i bypasses the boundary latch so a disable darkens the LED without waiting a period
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pwm_cnt <= '0;
         duty_q  <= '0;
         pwm_o   <= 1'b0;
      end else begin
         pwm_cnt <= (pwm_cnt == LAST) ? '0 : pwm_cnt + 1'b1;
         if (clr_i)
            duty_q <= '0;
         else if (pwm_cnt == LAST)
            duty_q <= duty_i;
         pwm_o <= (pwm_cnt < duty_q);
      end
   end

endmodule

// File: rtl/led_breather.sv
// Tick-driven LED breathing controller: ramp/hold FSM feeding a PWM generator.
// Define LED_BREATHER_GAMMA_EN for quadratic (perceptual) duty mapping; linear otherwise.
module led_breather
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned HOLD_TICKS = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                tick_i,
   output logic                led_o,
   output logic [PWM_BITS-1:0] level_o,
   output logic                peak_o
);

   localparam logic [PWM_BITS-1:0] MAX       = PWM_BITS'(max_level(PWM_BITS));
   localparam logic [7:0]          HOLD_LAST = 8'(HOLD_TICKS - 1);

   state_t              state;
   logic [7:0]          hold_cnt;
   logic [PWM_BITS-1:0] duty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         level_o  <= '0;
         hold_cnt <= '0;
         peak_o   <= 1'b0;
      end else begin
         peak_o <= 1'b0;
         if (!en_i) begin
            state    <= IDLE;
            level_o  <= '0;
            hold_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= RAMP_UP;
                  level_o  <= '0;
                  hold_cnt <= '0;
               end
               RAMP_UP:
                  if (tick_i) begin
                     if (level_o >= MAX - 1'b1) begin
                        level_o  <= MAX;
                        state    <= HOLD_HI;
                        hold_cnt <= '0;
                        peak_o   <= (level_o != MAX);
                     end else begin
                        level_o <= level_o + 1'b1;
                     end
                  end
               HOLD_HI:
                  if (tick_i) begin
                     if (hold_cnt >= HOLD_LAST) begin
                        state    <= RAMP_DOWN;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
               RAMP_DOWN:
                  if (tick_i) begin
                     if (level_o <= PWM_BITS'(1)) begin
                        level_o  <= '0;
                        state    <= HOLD_LO;
                        hold_cnt <= '0;
                     end else begin
                        level_o <= level_o - 1'b1;
                     end
                  end
               HOLD_LO:
                  if (tick_i) begin
                     if (hold_cnt >= HOLD_LAST) begin
                        state    <= RAMP_UP;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
               default: begin
                  state    <= IDLE;
                  level_o  <= '0;
                  hold_cnt <= '0;
               end
            endcase
         end
      end
   end

`ifdef LED_BREATHER_GAMMA_EN
   // level*(level+1) >> PWM_BITS maps 0->0 and MAX->MAX exactly
   logic [2*PWM_BITS:0] prod;
   always_comb begin
      prod = (2*PWM_BITS+1)'(level_o) * ((2*PWM_BITS+1)'(level_o) + 1'b1);
      duty = PWM_BITS'(prod >> PWM_BITS);
   end
`else
   always_comb begin
      duty = level_o;
   end
`endif

   pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (~en_i),
      .duty_i (duty),
      .pwm_o  (led_o)
   );

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather with PWM_BITS=4, HOLD_TICKS=2.
module tb_led_breather;
   import led_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       en_i;
   logic       tick_i;
   logic       led_o;
   logic [3:0] level_o;
   logic       peak_o;

   typedef struct packed {
      logic       pk;
      logic [3:0] lvl;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   peak_cnt = 0;

   led_breather #(.PWM_BITS(4), .HOLD_TICKS(2)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .tick_i  (tick_i),
      .led_o   (led_o),
      .level_o (level_o),
      .peak_o  (peak_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int exp_duty(input int lvl);
`ifdef LED_BREATHER_GAMMA_EN
      return (lvl * (lvl + 1)) >> 4;
`else
      return lvl;
`endif
   endfunction

   // monitor: every cycle with tick_i sampled high produces one scoreboard entry
   initial begin
      logic t;
      exp_t e;
      forever begin
         @(posedge clk_i);
         t = tick_i;
         @(negedge clk_i);
         if (t === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("tick_level", 32'(level_o), 32'(e.lvl));
               check("tick_peak", 32'(peak_o), 32'(e.pk));
            end
         end
      end
   end

   always @(negedge clk_i) if (peak_o === 1'b1) peak_cnt++;

   task automatic tick1(input int lvl, input logic pk);
      tick_i = 1'b1;
      exp_q.push_back('{pk: pk, lvl: 4'(lvl)});
      @(negedge clk_i);
      tick_i = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic count_high(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk_i);
         if (led_o === 1'b1) hi++;
      end
   endtask

   task automatic wait_rise(output logic found);
      logic prev;
      found = 1'b0;
      prev  = led_o;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk_i);
         if (prev === 1'b0 && led_o === 1'b1) found = 1'b1;
         prev = led_o;
      end
      check("pwm_rise_seen", 32'(found), 32'd1);
   endtask

   initial begin
      int   hi, w1, w2;
      logic found;
      rst_i  = 1'b1;
      en_i   = 1'b0;
      tick_i = 1'b0;
      #12;
      check("rst_level", 32'(level_o), 32'd0);
      check("rst_led", 32'(led_o), 32'd0);
      check("rst_peak", 32'(peak_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      gap(2);
      en_i = 1'b1;
      gap(3);
      check("idle_to_ramp_level", 32'(level_o), 32'd0);

      for (int k = 1; k <= 5; k++) begin
         tick1(k, 1'b0);
         gap(3);
      end
      gap(32);
      count_high(15, hi);
      check("pwm_level5_high", 32'(hi), 32'(exp_duty(5)));

      // change duty mid-pulse: current period must keep the old width
      wait_rise(found);
      w1 = 1;
      fork
         begin
            int a, b;
            count_high(14, a);
            count_high(15, b);
            w1 += a;
            w2 = b;
         end
         tick1(6, 1'b0);
      join
      check("pwm_old_period", 32'(w1), 32'(exp_duty(5)));
      check("pwm_new_period", 32'(w2), 32'(exp_duty(6)));
      gap(3);

      for (int k = 7; k <= 15; k++) begin
         tick1(k, k == 15);
         gap(3);
      end
      check("state_hold_hi", 32'(dut.state), 32'(HOLD_HI));
      check("peak_once", 32'(peak_cnt), 32'd1);
      gap(30);
      count_high(15, hi);
      check("pwm_level15_high", 32'(hi), 32'd15);

      tick1(15, 1'b0); gap(3);
      tick1(15, 1'b0); gap(3);
      for (int k = 14; k >= 0; k--) begin
         tick1(k, 1'b0);
         gap(3);
      end
      check("state_hold_lo", 32'(dut.state), 32'(HOLD_LO));
      gap(30);
      count_high(15, hi);
      check("pwm_level0_high", 32'(hi), 32'd0);
      tick1(0, 1'b0); gap(3);
      tick1(0, 1'b0); gap(3);
      tick1(1, 1'b0); gap(3);
      check("peak_still_once", 32'(peak_cnt), 32'd1);

      for (int k = 2; k <= 7; k++) begin
         tick1(k, 1'b0);
         gap(3);
      end
      gap(32);
      wait_rise(found);
      en_i = 1'b0;
      tick1(0, 1'b0);
      check("disable_state_idle", 32'(dut.state), 32'(IDLE));
      @(negedge clk_i);
      check("disable_led_dark", 32'(led_o), 32'd0);
      count_high(15, hi);
      check("disable_led_stays_dark", 32'(hi), 32'd0);
      en_i = 1'b1;
      gap(3);
      for (int k = 1; k <= 15; k++) begin
         tick1(k, k == 15);
         gap(3);
      end
      check("peak_second_ramp", 32'(peak_cnt), 32'd2);
      tick1(15, 1'b0); gap(3);
      tick1(15, 1'b0); gap(3);
      tick1(14, 1'b0); gap(3);
      tick1(13, 1'b0); gap(1);
      check("state_ramp_down", 32'(dut.state), 32'(RAMP_DOWN));

      #2 rst_i = 1'b1;
      #1;
      check("async_rst_level", 32'(level_o), 32'd0);
      check("async_rst_led", 32'(led_o), 32'd0);
      check("async_rst_peak", 32'(peak_o), 32'd0);
      check("async_rst_state", 32'(dut.state), 32'(IDLE));
      gap(3);
      rst_i = 1'b0;
      gap(3);
      tick1(1, 1'b0);
      gap(4);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
